// File: rtl/pc_run_monitor_if.sv
// Bundle of run-control inputs and status outputs exchanged between a host
// (bench or status logic) and pc_run_monitor.
interface pc_run_monitor_if #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned NUM_HALT = 2,
    parameter int unsigned CNT_W    = 32
);
    logic                         start;
    logic                         clear;
    logic [ADDR_W-1:0]            pc;
    logic                         pc_valid;
    logic [NUM_HALT*ADDR_W-1:0]   halt_addr;
    logic [NUM_HALT-1:0]          halt_en;
    logic [CNT_W-1:0]             timeout;

    logic                         running;
    logic                         halted;
    logic                         halt_pulse;
    logic [1:0]                   halt_cause;
    logic [2:0]                   halt_idx;
    logic [ADDR_W-1:0]            halt_pc;
    logic [CNT_W-1:0]             cycle_cnt;
    logic [CNT_W-1:0]             retire_cnt;

    modport master (
        output start, clear, pc, pc_valid, halt_addr, halt_en, timeout,
        input  running, halted, halt_pulse, halt_cause, halt_idx, halt_pc,
               cycle_cnt, retire_cnt
    );

    modport slave (
        input  start, clear, pc, pc_valid, halt_addr, halt_en, timeout,
        output running, halted, halt_pulse, halt_cause, halt_idx, halt_pc,
               cycle_cnt, retire_cnt
    );
endinterface

// File: rtl/pc_run_monitor.sv
// Watches the retiring PC stream and ends a run on a halt-address match,
// a jump-to-self loop or a cycle timeout; keeps cycle and retire counters.
module pc_run_monitor #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned NUM_HALT   = 2,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned LOOP_LIMIT = 4
) (
    input logic             clk,
    input logic             rstn,
    pc_run_monitor_if.slave bus
);
    localparam int unsigned LOOP_W = (LOOP_LIMIT > 2) ? $clog2(LOOP_LIMIT) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  retire_q, retire_d;
    logic [1:0]        cause_q, cause_d;
    logic [2:0]        idx_q, idx_d;
    logic [ADDR_W-1:0] hpc_q, hpc_d;
    logic              pulse_q, pulse_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [LOOP_W-1:0] loop_q, loop_d;

    logic       addr_hit, loop_hit, to_hit;
    logic [2:0] hit_idx;

    // Descending scan so the lowest matching entry is the one left standing.
    always_comb begin
        addr_hit = 1'b0;
        hit_idx  = 3'd0;
        for (int i = int'(NUM_HALT) - 1; i >= 0; i--) begin
            if (bus.pc_valid && bus.halt_en[i] &&
                bus.pc == bus.halt_addr[i*ADDR_W +: ADDR_W]) begin
                addr_hit = 1'b1;
                hit_idx  = 3'(i);
            end
        end
        loop_hit = bus.pc_valid && (bus.pc == last_q) &&
                   (loop_q == LOOP_W'(LOOP_LIMIT - 2));
        to_hit   = (bus.timeout != '0) && (cycle_q == bus.timeout - CNT_W'(1));
    end

    always_comb begin
        state_d  = state_q;
        cycle_d  = cycle_q;
        retire_d = retire_q;
        cause_d  = cause_q;
        idx_d    = idx_q;
        hpc_d    = hpc_q;
        pulse_d  = 1'b0;
        last_d   = last_q;
        loop_d   = loop_q;

        if (bus.clear) begin
            state_d  = StIdle;
            cycle_d  = '0;
            retire_d = '0;
            cause_d  = 2'd0;
            idx_d    = 3'd0;
            hpc_d    = '0;
            last_d   = '0;
            loop_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) state_d = StRun;
                end
                StRun: begin
                    if (cycle_q != '1) cycle_d = cycle_q + CNT_W'(1);
                    if (bus.pc_valid) begin
                        if (retire_q != '1) retire_d = retire_q + CNT_W'(1);
                        if (bus.pc == last_q) begin
                            if (loop_q != '1) loop_d = loop_q + LOOP_W'(1);
                        end else begin
                            loop_d = '0;
                            last_d = bus.pc;
                        end
                    end
                    if (addr_hit || loop_hit || to_hit) begin
                        state_d = StHalted;
                        pulse_d = 1'b1;
                        hpc_d   = bus.pc_valid ? bus.pc : '0;
                        idx_d   = addr_hit ? hit_idx : 3'd0;
                        cause_d = addr_hit ? 2'd1 : (loop_hit ? 2'd2 : 2'd3);
                    end
                end
                StHalted: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q  <= StIdle;
            cycle_q  <= '0;
            retire_q <= '0;
            cause_q  <= 2'd0;
            idx_q    <= 3'd0;
            hpc_q    <= '0;
            pulse_q  <= 1'b0;
            last_q   <= '0;
            loop_q   <= '0;
        end else begin
            state_q  <= state_d;
            cycle_q  <= cycle_d;
            retire_q <= retire_d;
            cause_q  <= cause_d;
            idx_q    <= idx_d;
            hpc_q    <= hpc_d;
            pulse_q  <= pulse_d;
            last_q   <= last_d;
            loop_q   <= loop_d;
        end
    end

    assign bus.running    = (state_q == StRun);
    assign bus.halted     = (state_q == StHalted);
    assign bus.halt_pulse = pulse_q;
    assign bus.halt_cause = cause_q;
    assign bus.halt_idx   = idx_q;
    assign bus.halt_pc    = hpc_q;
    assign bus.cycle_cnt  = cycle_q;
    assign bus.retire_cnt = retire_q;
endmodule

// File: tb/tb_pc_run_monitor.sv
// Directed bench for pc_run_monitor: a history-based reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_pc_run_monitor;
    localparam int unsigned AW = 32;
    localparam int unsigned NH = 2;
    localparam int unsigned CW = 32;
    localparam int unsigned LL = 4;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic              start, clear, pc_valid;
    logic [AW-1:0]     pc;
    logic [NH*AW-1:0]  halt_addr;
    logic [NH-1:0]     halt_en;
    logic [CW-1:0]     timeout;

    pc_run_monitor_if #(.ADDR_W(AW), .NUM_HALT(NH), .CNT_W(CW)) ifa ();
    pc_run_monitor_if #(.ADDR_W(AW), .NUM_HALT(NH), .CNT_W(4))  ifb ();

    assign ifa.start     = start;
    assign ifa.clear     = clear;
    assign ifa.pc        = pc;
    assign ifa.pc_valid  = pc_valid;
    assign ifa.halt_addr = halt_addr;
    assign ifa.halt_en   = halt_en;
    assign ifa.timeout   = timeout;

    assign ifb.start     = start;
    assign ifb.clear     = clear;
    assign ifb.pc        = pc;
    assign ifb.pc_valid  = pc_valid;
    assign ifb.halt_addr = '0;
    assign ifb.halt_en   = '0;
    assign ifb.timeout   = 4'd0;

    pc_run_monitor #(.ADDR_W(AW), .NUM_HALT(NH), .CNT_W(CW), .LOOP_LIMIT(LL)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (ifa.slave)
    );

    pc_run_monitor #(.ADDR_W(AW), .NUM_HALT(NH), .CNT_W(4), .LOOP_LIMIT(LL)) dut_sat (
        .clk  (clk),
        .rstn (rstn),
        .bus  (ifb.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: state 0=idle 1=run 2=halted; loop detection from full valid-PC history.
    int          m_state;
    longint      m_cyc, m_ret;
    logic [1:0]  m_cause;
    logic [2:0]  m_idx;
    logic [AW-1:0] m_hpc;
    logic        m_pulse;
    logic [AW-1:0] hist [0:255];
    int          hcount;

    always @(posedge clk) begin : model
        int     found;
        bit     lp;
        bit     to;
        longint ncyc;
        if (rstn || clear) begin
            m_state <= 0;
            m_cyc   <= 0;
            m_ret   <= 0;
            m_cause <= 2'd0;
            m_idx   <= 3'd0;
            m_hpc   <= '0;
            m_pulse <= 1'b0;
            hist[0] <= '0;
            hcount  <= 1;
        end else begin
            m_pulse <= 1'b0;
            if (m_state == 0) begin
                if (start) m_state <= 1;
            end else if (m_state == 1) begin
                found = -1;
                for (int i = NH - 1; i >= 0; i--)
                    if (pc_valid && halt_en[i] && pc == halt_addr[i*AW +: AW]) found = i;
                lp = 1'b0;
                if (pc_valid && hcount >= LL - 1) begin
                    lp = 1'b1;
                    for (int k = 1; k < LL; k++)
                        if (hist[hcount-k] != pc) lp = 1'b0;
                end
                ncyc = m_cyc + 1;
                to = (timeout != 0) && (ncyc == longint'(timeout));
                m_cyc <= ncyc;
                if (pc_valid) begin
                    m_ret        <= m_ret + 1;
                    hist[hcount] <= pc;
                    hcount       <= hcount + 1;
                end
                if (found >= 0 || lp || to) begin
                    m_state <= 2;
                    m_pulse <= 1'b1;
                    m_hpc   <= pc_valid ? pc : '0;
                    m_cause <= (found >= 0) ? 2'd1 : (lp ? 2'd2 : 2'd3);
                    m_idx   <= (found >= 0) ? 3'(found) : 3'd0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("running",    64'(ifa.running),    64'(m_state == 1));
            chk("halted",     64'(ifa.halted),     64'(m_state == 2));
            chk("halt_pulse", 64'(ifa.halt_pulse), 64'(m_pulse));
            chk("halt_cause", 64'(ifa.halt_cause), 64'(m_cause));
            chk("halt_idx",   64'(ifa.halt_idx),   64'(m_idx));
            chk("halt_pc",    64'(ifa.halt_pc),    64'(m_hpc));
            chk("cycle_cnt",  64'(ifa.cycle_cnt),  64'(m_cyc));
            chk("retire_cnt", 64'(ifa.retire_cnt), 64'(m_ret));
            if (ifa.halt_pulse) pulses++;
        end
    end

    task automatic cyc(input bit s, input bit c, input bit v, input logic [AW-1:0] p);
        start    = s;
        clear    = c;
        pc_valid = v;
        pc       = p;
        @(posedge clk);
        #1;
        start    = 1'b0;
        clear    = 1'b0;
        pc_valid = 1'b0;
        pc       = '0;
    endtask

    task automatic lit_status(input string tag, input logic run, input logic hlt,
                              input logic [1:0] cause, input logic [2:0] idx,
                              input logic [AW-1:0] hpc, input longint cy, input longint rt);
        chk({tag, ".running"},    64'(ifa.running),    64'(run));
        chk({tag, ".halted"},     64'(ifa.halted),     64'(hlt));
        chk({tag, ".halt_cause"}, 64'(ifa.halt_cause), 64'(cause));
        chk({tag, ".halt_idx"},   64'(ifa.halt_idx),   64'(idx));
        chk({tag, ".halt_pc"},    64'(ifa.halt_pc),    64'(hpc));
        chk({tag, ".cycle_cnt"},  64'(ifa.cycle_cnt),  64'(cy));
        chk({tag, ".retire_cnt"}, 64'(ifa.retire_cnt), 64'(rt));
    endtask

    initial begin
        int p0;
        rstn = 1'b1;
        start = 1'b0; clear = 1'b0; pc_valid = 1'b0; pc = '0;
        halt_addr = '0; halt_en = '0; timeout = '0;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        rstn = 1'b0;
        chk_en = 1'b1;
        lit_status("reset", 0, 0, 2'd0, 3'd0, 0, 0, 0);
        chk("reset.halt_pulse", 64'(ifa.halt_pulse), 64'd0);

        // Address halt at 0x1c
        halt_addr = {32'h0, 32'h1c};
        halt_en   = 2'b01;
        p0 = pulses;
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 32'(i * 4));
        lit_status("addr", 0, 1, 2'd1, 3'd0, 32'h1c, 8, 8);
        chk("addr.halt_pulse", 64'(ifa.halt_pulse), 64'd1);
        cyc(1, 0, 1, 32'h20);
        chk("addr.pulse_drop", 64'(ifa.halt_pulse), 64'd0);
        lit_status("addr.start_ignored", 0, 1, 2'd1, 3'd0, 32'h1c, 8, 8);
        cyc(0, 0, 0, 0);
        chk("addr.pulse_count", 64'(pulses - p0), 64'd1);
        cyc(1, 1, 0, 0);
        lit_status("start_clear", 0, 0, 2'd0, 3'd0, 0, 0, 0);

        // Priority: disabled entry 0, enabled entry 1, same address
        halt_addr = {32'h40, 32'h40};
        halt_en   = 2'b10;
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 32'h40);
        lit_status("prio", 0, 1, 2'd1, 3'd1, 32'h40, 1, 1);
        cyc(0, 1, 0, 0);

        // Self-loop with a bubble inside
        halt_en = 2'b00;
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 32'h10);
        cyc(0, 0, 1, 32'h14);
        cyc(0, 0, 1, 32'h14);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 32'h14);
        chk("loop.not_yet", 64'(ifa.halted), 64'd0);
        cyc(0, 0, 1, 32'h14);
        lit_status("loop", 0, 1, 2'd2, 3'd0, 32'h14, 6, 5);
        cyc(0, 1, 0, 0);

        // Timeout of 5 with no valid PCs
        timeout = 5;
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
        chk("tmo.not_yet", 64'(ifa.halted), 64'd0);
        cyc(0, 0, 0, 0);
        lit_status("tmo", 0, 1, 2'd3, 3'd0, 0, 5, 0);
        cyc(0, 1, 0, 0);

        // Timeout disabled: 100 cycles, also exercises the 4-bit saturating instance
        timeout = 0;
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 100; i++) begin
            cyc(0, 0, 0, 0);
            if (i == 19) chk("sat.cycle_cnt20", 64'(ifb.cycle_cnt), 64'd15);
        end
        lit_status("no_tmo", 1, 0, 2'd0, 3'd0, 0, 100, 0);
        chk("sat.cycle_cnt100", 64'(ifb.cycle_cnt), 64'd15);
        chk("sat.running", 64'(ifb.running), 64'd1);
        cyc(0, 1, 0, 0);

        // Clear mid-run aborts without a pulse
        p0 = pulses;
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 32'h200);
        cyc(0, 0, 1, 32'h204);
        cyc(0, 1, 1, 32'h208);
        lit_status("abort", 0, 0, 2'd0, 3'd0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("abort.no_pulse", 64'(pulses - p0), 64'd0);

        // Reset mid-run at cycle_cnt=3
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 32'h100);
        cyc(0, 0, 1, 32'h104);
        cyc(0, 0, 1, 32'h108);
        lit_status("pre_rst", 1, 0, 2'd0, 3'd0, 0, 3, 3);
        rstn = 1'b1;
        cyc(1, 0, 1, 32'h10c);
        rstn = 1'b0;
        lit_status("mid_rst", 0, 0, 2'd0, 3'd0, 0, 0, 0);
        chk("mid_rst.halt_pulse", 64'(ifa.halt_pulse), 64'd0);
        cyc(0, 0, 0, 0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
